// File: rtl/hex_digit_scanner_if.sv
// Display-side bus of the hex digit scanner: load/value/blank_lz requests in,
// multiplexed digit code, one-hot select, blank flag and frame/commit strobes out.
// master = display controller (drives requests), slave = scanner (drives display signals).
interface hex_digit_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  logic [3:0]                digit;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      blank;
  logic                      frame_done;
  logic                      load_ack;

  modport master (
    output load, value, blank_lz,
    input  digit, digit_sel, blank, frame_done, load_ack
  );

  modport slave (
    input  load, value, blank_lz,
    output digit, digit_sel, blank, frame_done, load_ack
  );
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes a NUM_DIGITS-wide hex value onto one shared 4-bit digit bus.
// Each digit is held PRESCALE cycles; outputs are registered, one cycle behind scan state.
// load is never back-pressured: last write before a frame boundary wins, one load_ack per commit.
// Ports: clock/reset (sync, active-high); bus.slave carries load/value/blank_lz in and
// digit/digit_sel/blank/frame_done/load_ack out.
module hex_digit_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  hex_digit_scanner_if.slave   bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Scan state
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  // Double buffer: pend_q collects loads, disp_q is what is being scanned out
  logic [VW-1:0]         pend_q, pend_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [VW-1:0]         disp_q, disp_d;
  // Wrap/commit events, delayed one stage so the strobes line up with the
  // registered digit_sel returning to bit 0 and the new value appearing
  logic                  wrap_q, wrap_d;
  logic                  ack_q, ack_d;
  // Output registers
  logic [3:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_ack_q, load_ack_d;

  logic tick;
  logic boundary;
  logic nz_above;

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    disp_d       = disp_q;
    wrap_d       = boundary;
    ack_d        = boundary && pend_vld_q;
    frame_done_d = wrap_q;
    load_ack_d   = ack_q;

    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // Commit uses pend_q as it was before this edge; a load on the same
    // edge still lands in pend_q and keeps the pending flag set.
    if (boundary && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (bus.load) begin
      pend_d     = bus.value;
      pend_vld_d = 1'b1;
    end

    digit_d = disp_q[4*idx_q +: 4];
    sel_d   = NUM_DIGITS'(1) << idx_q;

    // Leading-zero test: any non-zero nibble at or above the current digit
    nz_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) begin
        nz_above = 1'b1;
      end
    end
    blank_d = bus.blank_lz && (idx_q != '0) && !nz_above;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      disp_q       <= '0;
      wrap_q       <= 1'b0;
      ack_q        <= 1'b0;
      digit_q      <= 4'h0;
      sel_q        <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      disp_q       <= disp_d;
      wrap_q       <= wrap_d;
      ack_q        <= ack_d;
      digit_q      <= digit_d;
      sel_q        <= sel_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.digit_sel  = sel_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_ack   = load_ack_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with NUM_DIGITS=4, PRESCALE=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hex_digit_scanner;

  logic clock;
  logic reset;
  int   ncmp;
  int   nfail;

  hex_digit_scanner_if #(.NUM_DIGITS(4)) bus ();

  hex_digit_scanner #(
    .NUM_DIGITS (4),
    .PRESCALE   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".sel"},   32'(bus.digit_sel),  32'h0);
    chk({tag, ".digit"}, 32'(bus.digit),      32'h0);
    chk({tag, ".blank"}, 32'(bus.blank),      32'h1);
    chk({tag, ".fd"},    32'(bus.frame_done), 32'h0);
    chk({tag, ".ack"},   32'(bus.load_ack),   32'h0);
  endtask

  // Walks ncyc output cycles of one frame, starting at the cycle where
  // digit_sel is 0001. Loads are driven at the end of the given cycles;
  // blank_lz is dropped at the end of cycle blz_off_at.
  task automatic frame(input string tag, input logic [15:0] val, input logic [3:0] bmask,
                       input logic efd, input logic eack,
                       input int load_at, input logic [15:0] lval,
                       input int load2_at, input logic [15:0] lval2,
                       input int blz_off_at, input int ncyc);
    logic [15:0] v;
    logic [3:0]  exp_sel;
    logic        exp_bl;
    int          d;
    v = val;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clock);
      bus.load = 1'b0;
      d        = k / 4;
      exp_sel  = 4'b0001 << d;
      exp_bl   = (blz_off_at >= 0 && k > blz_off_at) ? 1'b0 : bmask[d];
      chk($sformatf("%s[%0d].sel", tag, k),   32'(bus.digit_sel),  32'(exp_sel));
      chk($sformatf("%s[%0d].digit", tag, k), 32'(bus.digit),      32'(v[4*d +: 4]));
      chk($sformatf("%s[%0d].blank", tag, k), 32'(bus.blank),      32'(exp_bl));
      chk($sformatf("%s[%0d].fd", tag, k),    32'(bus.frame_done), 32'((k == 0) ? efd : 1'b0));
      chk($sformatf("%s[%0d].ack", tag, k),   32'(bus.load_ack),   32'((k == 0) ? eack : 1'b0));
      if (k == load_at) begin
        bus.load  = 1'b1;
        bus.value = lval;
      end
      if (k == load2_at) begin
        bus.load  = 1'b1;
        bus.value = lval2;
      end
      if (k == blz_off_at) bus.blank_lz = 1'b0;
    end
  endtask

  initial begin
    ncmp         = 0;
    nfail        = 0;
    reset        = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0;
    bus.blank_lz = 1'b0;

    repeat (3) @(negedge clock);
    chk_reset("reset");
    reset = 1'b0;

    // Idle scan after reset, then a load at idx 1 committed at the wrap
    frame("idle0",  16'h0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0,    -1, 16'h0,    -1, 16);
    frame("idle1",  16'h0000, 4'b0000, 1'b1, 1'b0,  5, 16'h1A3F, -1, 16'h0,    -1, 16);
    // 1A3F on display; two loads in one frame, last write wins
    frame("v1a3f",  16'h1A3F, 4'b0000, 1'b1, 1'b1,  1, 16'h1111,  9, 16'h2222, -1, 16);
    bus.blank_lz = 1'b1;
    frame("v2222",  16'h2222, 4'b0000, 1'b1, 1'b1,  2, 16'h0050, -1, 16'h0,    -1, 16);
    frame("v0050",  16'h0050, 4'b1100, 1'b1, 1'b1,  2, 16'h0000, -1, 16'h0,    -1, 16);
    // All-zero value keeps digit 0; blank_lz dropped mid-frame; AAAA pending,
    // then BBBB loaded on the boundary edge itself
    frame("v0000",  16'h0000, 4'b1110, 1'b1, 1'b1,  8, 16'hAAAA, 14, 16'hBBBB,  5, 16);
    frame("vaaaa",  16'hAAAA, 4'b0000, 1'b1, 1'b1, -1, 16'h0,    -1, 16'h0,    -1, 16);
    // BBBB from the second commit; 1234 loaded then lost to a reset at idx 2
    frame("vbbbb",  16'hBBBB, 4'b0000, 1'b1, 1'b1,  3, 16'h1234, -1, 16'h0,    -1, 10);

    reset = 1'b1;
    @(negedge clock);
    chk_reset("midrst0");
    @(negedge clock);
    chk_reset("midrst1");
    reset = 1'b0;

    frame("post0",  16'h0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0,    -1, 16'h0,    -1, 16);
    frame("post1",  16'h0000, 4'b0000, 1'b1, 1'b0, -1, 16'h0,    -1, 16'h0,    -1, 16);
    frame("post2",  16'h0000, 4'b0000, 1'b1, 1'b0, -1, 16'h0,    -1, 16'h0,    -1, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
